draw_scheduler: RTL

Per-frame sequencer for the object-mux/rectangle-draw datapath. Paces frames from an internal tick counter and runs an erase pass over all active objects. Between passes it pulses a game-state update, then runs a draw pass. For each object it drives the mux select (`control_signal`) and handshakes with the rectangle drawer via `draw_start`/`draw_done`.

---
 rtl/draw_scheduler.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
`timescale 1ns/1ps
// draw_scheduler: per-frame sequencer for the object-mux / rectangle-draw datapath.
// A free-running tick counter paces frames. Each frame runs an erase pass over the
// latched object mask, pulses a game-state update, re-latches the mask and runs a
// draw pass. Every output is a flop whose value is decoded from the next state, so
// the outputs always describe the state the scheduler is currently in.
module draw_scheduler #(
    parameter int FRAME_TICKS = 833334,
    parameter int TICK_W      = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [5:0] obj_active,
    input  logic       draw_done,
    output logic [3:0] control_signal,
    output logic       draw_start,
    output logic       erase,
    output logic       update_en,
    output logic       frame_busy,
    output logic       frame_missed
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_E_SEL   = 4'd1,
        S_E_ISSUE = 4'd2,
        S_E_WAIT  = 4'd3,
        S_UPDATE  = 4'd4,
        S_D_SEL   = 4'd5,
        S_D_ISSUE = 4'd6,
        S_D_WAIT  = 4'd7
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [2:0]        idx_q, idx_d;
    logic [5:0]        mask_q, mask_d;

    logic [3:0]        control_signal_q, control_signal_d;
    logic              draw_start_q, draw_start_d;
    logic              erase_q, erase_d;
    logic              update_en_q, update_en_d;
    logic              frame_busy_q, frame_busy_d;
    logic              frame_missed_q, frame_missed_d;

    logic              tick_s;
    logic              idle_s;
    logic              start_s;
    logic [7:0]        mask_ext_s;
    logic              obj_sel_s;
    logic              idx_done_s;

    // Frame pacing: tick on the last count of each period.
    assign tick_s     = (cnt_q == TICK_W'(FRAME_TICKS - 1));
    assign idle_s     = (state_q == S_IDLE);
    assign start_s    = idle_s & enable & (tick_s | pending_q);
    // Bit k of the extended mask is object k, so idx indexes it directly and
    // idx = 7 (end of pass) reads a constant zero instead of running off the end.
    assign mask_ext_s = {1'b0, mask_q, 1'b0};
    assign obj_sel_s  = mask_ext_s[idx_q];
    assign idx_done_s = (idx_q > 3'd6);

    // Free-running frame counter, wraps every period independent of state/enable.
    always_comb begin
        cnt_d = cnt_q;
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    // Pending-frame flag: remembers one tick that arrived while a frame was running.
    always_comb begin
        pending_d = pending_q;
        if (!enable) begin
            pending_d = 1'b0;
        end else if (start_s) begin
            pending_d = 1'b0;
        end else if (tick_s && !idle_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Next-state logic: walk object indices 1..6 in each pass.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    mask_d  = obj_active;
                    idx_d   = 3'd1;
                    state_d = S_E_SEL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_E_SEL: begin
                if (idx_done_s) begin
                    state_d = S_UPDATE;
                end else if (obj_sel_s) begin
                    state_d = S_E_ISSUE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_E_ISSUE: begin
                state_d = S_E_WAIT;
            end
            S_E_WAIT: begin
                if (draw_done) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_E_SEL;
                end else begin
                    state_d = S_E_WAIT;
                end
            end
            S_UPDATE: begin
                // Objects created/destroyed by the update show up in the draw pass.
                mask_d  = obj_active;
                idx_d   = 3'd1;
                state_d = S_D_SEL;
            end
            S_D_SEL: begin
                if (idx_done_s) begin
                    state_d = S_IDLE;
                end else if (obj_sel_s) begin
                    state_d = S_D_ISSUE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_D_ISSUE: begin
                state_d = S_D_WAIT;
            end
            S_D_WAIT: begin
                if (draw_done) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_D_SEL;
                end else begin
                    state_d = S_D_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        control_signal_d = 4'd0;
        draw_start_d     = 1'b0;
        erase_d          = 1'b0;
        update_en_d      = 1'b0;
        frame_busy_d     = (state_d != S_IDLE);
        frame_missed_d   = enable & tick_s & ~idle_s & pending_q;
        case (state_d)
            S_E_SEL: begin
                erase_d = 1'b1;
            end
            S_E_ISSUE: begin
                erase_d          = 1'b1;
                draw_start_d     = 1'b1;
                control_signal_d = {1'b0, idx_d};
            end
            S_E_WAIT: begin
                erase_d          = 1'b1;
                control_signal_d = {1'b0, idx_d};
            end
            S_UPDATE: begin
                update_en_d = 1'b1;
            end
            S_D_ISSUE: begin
                draw_start_d     = 1'b1;
                control_signal_d = {1'b0, idx_d};
            end
            S_D_WAIT: begin
                control_signal_d = {1'b0, idx_d};
            end
            default: begin
                control_signal_d = 4'd0;
            end
        endcase
    end

    // State, counter and bookkeeping registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            idx_q     <= 3'd0;
            mask_q    <= 6'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
        end
    end

    // Registered outputs; reset drops draw_start and everything else at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            control_signal_q <= 4'd0;
            draw_start_q     <= 1'b0;
            erase_q          <= 1'b0;
            update_en_q      <= 1'b0;
            frame_busy_q     <= 1'b0;
            frame_missed_q   <= 1'b0;
        end else begin
            control_signal_q <= control_signal_d;
            draw_start_q     <= draw_start_d;
            erase_q          <= erase_d;
            update_en_q      <= update_en_d;
            frame_busy_q     <= frame_busy_d;
            frame_missed_q   <= frame_missed_d;
        end
    end

    assign control_signal = control_signal_q;
    assign draw_start     = draw_start_q;
    assign erase          = erase_q;
    assign update_en      = update_en_q;
    assign frame_busy     = frame_busy_q;
    assign frame_missed   = frame_missed_q;

endmodule
